// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg -- shared encodings for the JK register bank.
//   jk_act_e  : per-bit JK action, {j,k} packed as a 2-bit value.
//   jk_mode_e : bank operating mode as presented on the 'mode' port.
// -----------------------------------------------------------------------------
package jk_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'b00,
        ACT_RESET  = 2'b01,
        ACT_SET    = 2'b10,
        ACT_TOGGLE = 2'b11
    } jk_act_e;

    typedef enum logic [1:0] {
        MODE_JK     = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_CNT_UP = 2'b10,
        MODE_CNT_DN = 2'b11
    } jk_mode_e;

endpackage

// File: rtl/jk_ff_cell.sv
// -----------------------------------------------------------------------------
// jk_ff_cell -- one JK flip-flop bit with parallel-load override.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, loads RST_VAL
//   en    : clock enable; q holds when low
//   load  : when high (and en), q takes d; j/k ignored
//   d     : load data
//   j, k  : JK controls (hold / clear / set / toggle)
//   q     : registered bit
// -----------------------------------------------------------------------------
module jk_ff_cell
    import jk_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  logic d,
    input  logic j,
    input  logic k,
    output logic q
);

    jk_act_e act;
    assign act = jk_act_e'({j, k});

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            if (load) begin
                q <= d;
            end else begin
                case (act)
                    ACT_HOLD:   q <= q;
                    ACT_RESET:  q <= 1'b0;
                    ACT_SET:    q <= 1'b1;
                    ACT_TOGGLE: q <= ~q;
                    default:    q <= q;
                endcase
            end
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// -----------------------------------------------------------------------------
// jk_reg_bank -- WIDTH-bit bank of JK flip-flops with load and up/down count.
//   clk, rst   : clock and synchronous active-high reset (q <= RST_VAL)
//   en         : clock enable; q holds and tc is 0 when low
//   mode       : 00 JK, 01 LOAD, 10 CNT_UP, 11 CNT_DN
//   j, k       : per-bit JK controls (JK mode)
//   d          : parallel load data (LOAD mode)
//   q, q_bar   : registered state and its complement
//   tc         : combinational terminal count (all-ones going up, zero going down)
//   chg        : only with macro JK_CHG_FLAG_EN -- registered, high for one
//                cycle after any non-reset edge at which q changed
// Counting is done by driving every cell with j=k=toggle-enable, where a bit
// toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
// -----------------------------------------------------------------------------
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
`ifdef JK_CHG_FLAG_EN
    ,
    output logic             chg
`endif
);

    jk_mode_e         mode_e;
    logic [WIDTH-1:0] up_te, dn_te;
    logic [WIDTH-1:0] cell_j, cell_k;
    logic             load;

    assign mode_e = jk_mode_e'(mode);
    assign load   = (mode_e == MODE_LOAD);

    // Ripple the "all lower bits are 1/0" condition from bit 0 upward.
    always_comb begin : te_chain
        logic up_all1, dn_all0;
        up_all1 = 1'b1;
        dn_all0 = 1'b1;
        up_te   = '0;
        dn_te   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_te[i] = up_all1;
            dn_te[i] = dn_all0;
            up_all1  = up_all1 & q[i];
            dn_all0  = dn_all0 & ~q[i];
        end
    end

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        case (mode_e)
            MODE_JK: begin
                cell_j = j;
                cell_k = k;
            end
            MODE_CNT_UP: begin
                cell_j = up_te;
                cell_k = up_te;
            end
            MODE_CNT_DN: begin
                cell_j = dn_te;
                cell_k = dn_te;
            end
            default: begin
                cell_j = '0;
                cell_k = '0;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .load (load),
            .d    (d[i]),
            .j    (cell_j[i]),
            .k    (cell_k[i]),
            .q    (q[i])
        );
    end

    assign q_bar = ~q;
    assign tc    = en & (((mode_e == MODE_CNT_UP) & (&q)) |
                         ((mode_e == MODE_CNT_DN) & ~(|q)));

`ifdef JK_CHG_FLAG_EN
    logic [WIDTH-1:0] flip;
    logic             chg_q, chg_d;

    // A bit flips when set/toggled from 0, cleared/toggled from 1, or loaded
    // with a differing value.
    assign flip  = load ? (d ^ q) : ((cell_j & ~q) | (cell_k & q));
    assign chg_d = en & (|flip);

    always_ff @(posedge clk) begin
        if (rst) chg_q <= 1'b0;
        else     chg_q <= chg_d;
    end

    assign chg = chg_q;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;

    localparam int         W    = 4;
    localparam logic [3:0] RSTV = 4'h5;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, d, q, q_bar;
    logic         tc;
`ifdef JK_CHG_FLAG_EN
    logic         chg;
`endif

    int errors = 0;
    int checks = 0;

    jk_reg_bank #(.WIDTH(W), .RST_VAL(RSTV)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .j     (j),
        .k     (k),
        .d     (d),
        .q     (q),
        .q_bar (q_bar),
        .tc    (tc)
`ifdef JK_CHG_FLAG_EN
        ,
        .chg   (chg)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural reference: integer state updated from the mode rules.
    int unsigned mq;
    logic        mvalid = 1'b0;
    logic        mchg;

    always @(posedge clk) begin
        int unsigned nq;
        nq = mq;
        if (rst) begin
            mq     = RSTV;
            mchg   = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (en) begin
                case (mode)
                    2'd0: nq = ((mq & ~32'(k)) | (~mq & 32'(j))) & 32'hF;
                    2'd1: nq = d;
                    2'd2: nq = (mq + 1) % 16;
                    default: nq = (mq + 15) % 16;
                endcase
            end
            mchg = (nq != mq);
            mq   = nq;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            check("q", 32'(q), mq);
            check("q_bar", 32'(q_bar), (~mq) & 32'hF);
            check("tc", 32'(tc), 32'(en && ((mode == 2'd2 && mq == 15) || (mode == 2'd3 && mq == 0))));
`ifdef JK_CHG_FLAG_EN
            check("chg", 32'(chg), 32'(mchg));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; j = '0; k = '0; d = '0;

        // Reset
        en = 1'b1;
        step();
        check("rst_q", 32'(q), 32'h5);
        check("rst_qbar", 32'(q_bar), 32'hA);
        check("rst_tc", 32'(tc), 0);
        rst = 1'b0;

        // JK sequence from 0000
        mode = 2'd1; d = 4'h0; step();
        check("load0", 32'(q), 32'h0);
        mode = 2'd0; j = 4'hF; k = 4'h0; step();
        check("jk_set", 32'(q), 32'hF);
        j = 4'h3; k = 4'hC; step();
        check("jk_mix", 32'(q), 32'h3);
        j = 4'hF; k = 4'hF; step();
        check("jk_tog", 32'(q), 32'hC);
        j = 4'h0; k = 4'h0; step();
        check("jk_hold", 32'(q), 32'hC);

        // Load then count up through wrap
        mode = 2'd1; d = 4'hD; step();
        check("load_d", 32'(q), 32'hD);
        mode = 2'd2; step();
        check("up1", 32'(q), 32'hE);
        step();
        check("up2", 32'(q), 32'hF);
        check("up2_tc", 32'(tc), 1);
        step();
        check("up3_wrap", 32'(q), 32'h0);
        check("up3_tc", 32'(tc), 0);

        // Count down through wrap, then disable
        mode = 2'd1; d = 4'h1; step();
        mode = 2'd3; step();
        check("dn1", 32'(q), 32'h0);
        check("dn1_tc", 32'(tc), 1);
        step();
        check("dn2_wrap", 32'(q), 32'hF);
        check("dn2_tc", 32'(tc), 0);
        en = 1'b0; step(); step();
        check("en0_q", 32'(q), 32'hF);
        check("en0_tc", 32'(tc), 0);

        // Reset mid-count
        en = 1'b1; mode = 2'd1; d = 4'h6; step();
        mode = 2'd2; rst = 1'b1; step();
        check("midrst_q", 32'(q), 32'h5);
        rst = 1'b0; step();
        check("midrst_up", 32'(q), 32'h6);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 24) == 0);
            en   = ($urandom_range(0, 5) != 0);
            mode = 2'($urandom_range(0, 3));
            j    = 4'($urandom);
            k    = 4'($urandom);
            d    = 4'($urandom);
            step();
        end

`ifdef JK_CHG_FLAG_EN
        rst = 1'b1; en = 1'b1; mode = 2'd0; j = '0; k = '0; step();
        check("chg_rst", 32'(chg), 0);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            check("chg_hold", 32'(chg), 0);
        end
        j = 4'h1; k = 4'h1; step();
        check("chg_tog", 32'(chg), 1);
        check("chg_tog_q", 32'(q), 32'h4);
        j = 4'h0; k = 4'h0; step();
        check("chg_once", 32'(chg), 0);
        mode = 2'd1; d = 4'h4; step();
        check("chg_same_load", 32'(chg), 0);
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
